// File: rtl/decode_trig_pkg.sv
// Shared types and constants for the decoded-byte pattern trigger.
// Pure declarations; no timing or flow-control behaviour of its own.
package decode_trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_FIRE  = 2'b10
    } trig_state_t;

    localparam int LANE_W            = 8;
    localparam int MAX_PATTERN_BYTES = 16;

endpackage

// File: rtl/decode_pattern_window.sv
// Sliding byte window with fill tracking and masked compare; match_r pulses one cycle
// after the shift that completes a match. No backpressure: every strobed byte is taken.
module decode_pattern_window
    import decode_trig_pkg::*;
#(
    parameter int PATTERN_BYTES = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [LANE_W-1:0]                 byte_i,
    input  logic                              byte_valid_i,
    input  logic [LANE_W*PATTERN_BYTES-1:0]   pattern_i,
    input  logic [LANE_W*PATTERN_BYTES-1:0]   mask_i,
    input  logic                              fill_clr,
    output logic                              match_r
);

    localparam int FILL_W = $clog2(PATTERN_BYTES + 1);

    if (PATTERN_BYTES < 1 || PATTERN_BYTES > MAX_PATTERN_BYTES) begin : g_bad_depth
        $error("PATTERN_BYTES out of range");
    end

    logic [LANE_W-1:0] win [PATTERN_BYTES];
    logic [FILL_W-1:0] fill;
    logic              shifted;
    logic              all_pass;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PATTERN_BYTES; i++) win[i] <= '0;
            shifted <= 1'b0;
        end else begin
            shifted <= byte_valid_i;
            if (byte_valid_i) begin
                for (int i = PATTERN_BYTES - 1; i > 0; i--) win[i] <= win[i-1];
                win[0] <= byte_i;
            end
        end
    end

    // A clear coinciding with a byte wins: the byte is shifted in but not counted.
    always_ff @(posedge clk) begin
        if (reset || fill_clr) begin
            fill <= '0;
        end else if (byte_valid_i && fill != FILL_W'(PATTERN_BYTES)) begin
            fill <= fill + FILL_W'(1);
        end
    end

    always_comb begin
        all_pass = |mask_i;
        for (int i = 0; i < PATTERN_BYTES; i++) begin
            if (((win[i] ^ pattern_i[LANE_W*i +: LANE_W]) & mask_i[LANE_W*i +: LANE_W]) != '0)
                all_pass = 1'b0;
            if (mask_i[LANE_W*i +: LANE_W] != '0 && fill <= FILL_W'(i))
                all_pass = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) match_r <= 1'b0;
        else       match_r <= shifted && all_pass;
    end

endmodule

// File: rtl/decode_pattern_trigger.sv
// Arm/fire/re-arm trigger on the Nth masked pattern match; trig_out rises 2 cycles after the
// completing byte and is stretched. No backpressure. Optional DECODE_TRIG_TIMEOUT_EN adds an inter-byte fill timeout.
module decode_pattern_trigger
    import decode_trig_pkg::*;
#(
    parameter int PATTERN_BYTES  = 8,
    parameter int COUNT_W        = 8,
`ifdef DECODE_TRIG_TIMEOUT_EN
    parameter int TIMEOUT_W      = 16,
`endif
    parameter int STRETCH_CYCLES = 127
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [LANE_W-1:0]                 byte_i,
    input  logic                              byte_valid_i,
    input  logic [LANE_W*PATTERN_BYTES-1:0]   pattern_i,
    input  logic [LANE_W*PATTERN_BYTES-1:0]   mask_i,
    input  logic [COUNT_W-1:0]                match_count_i,
    input  logic                              rearm_i,
    input  logic                              arm_i,
    input  logic                              disarm_i,
`ifdef DECODE_TRIG_TIMEOUT_EN
    input  logic [TIMEOUT_W-1:0]              timeout_i,
`endif
    output logic                              trig_out,
    output logic                              armed_o,
    output logic [COUNT_W-1:0]                match_total_o,
    output logic [1:0]                        state_o
);

    localparam int SW = $clog2(STRETCH_CYCLES + 1);

    trig_state_t        state, state_nxt;
    logic [COUNT_W-1:0] remaining, remaining_nxt;
    logic [COUNT_W-1:0] total_nxt;
    logic [SW-1:0]      stretch, stretch_nxt;
    logic               trig_nxt;
    logic               fill_clr;
    logic               match_r;
    logic               timeout_hit;
    logic [COUNT_W-1:0] reload;

    assign reload = (match_count_i == '0) ? COUNT_W'(1) : match_count_i;

    decode_pattern_window #(
        .PATTERN_BYTES (PATTERN_BYTES)
    ) u_window (
        .clk          (clk),
        .reset        (reset),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .pattern_i    (pattern_i),
        .mask_i       (mask_i),
        .fill_clr     (fill_clr),
        .match_r      (match_r)
    );

`ifdef DECODE_TRIG_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] idle_cnt;

    // Counter parks at the limit, so the clear keeps asserting for the rest of the gap.
    assign timeout_hit = (timeout_i != '0) && !byte_valid_i && (idle_cnt == timeout_i);

    always_ff @(posedge clk) begin
        if (reset || byte_valid_i) idle_cnt <= '0;
        else if (timeout_i != '0 && idle_cnt != timeout_i) idle_cnt <= idle_cnt + TIMEOUT_W'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            remaining     <= '0;
            match_total_o <= '0;
            stretch       <= '0;
            trig_out      <= 1'b0;
        end else begin
            state         <= state_nxt;
            remaining     <= remaining_nxt;
            match_total_o <= total_nxt;
            stretch       <= stretch_nxt;
            trig_out      <= trig_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        total_nxt     = match_total_o;
        stretch_nxt   = stretch;
        trig_nxt      = trig_out;
        fill_clr      = timeout_hit;

        if (disarm_i) begin
            state_nxt   = ST_IDLE;
            trig_nxt    = 1'b0;
            stretch_nxt = '0;
            fill_clr    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm_i) begin
                        state_nxt     = ST_ARMED;
                        remaining_nxt = reload;
                        total_nxt     = '0;
                        fill_clr      = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (arm_i) begin
                        remaining_nxt = reload;
                        total_nxt     = '0;
                        fill_clr      = 1'b1;
                    end else if (match_r) begin
                        if (match_total_o != '1) total_nxt = match_total_o + COUNT_W'(1);
                        remaining_nxt = remaining - COUNT_W'(1);
                        if (remaining <= COUNT_W'(1)) begin
                            state_nxt   = ST_FIRE;
                            trig_nxt    = 1'b1;
                            stretch_nxt = SW'(1);
                        end
                    end
                end
                ST_FIRE: begin
                    if (stretch == SW'(STRETCH_CYCLES)) begin
                        trig_nxt    = 1'b0;
                        stretch_nxt = '0;
                        if (rearm_i) begin
                            state_nxt     = ST_ARMED;
                            remaining_nxt = reload;
                            fill_clr      = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        stretch_nxt = stretch + SW'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign armed_o = (state == ST_ARMED);
    assign state_o = state;

endmodule

// File: tb/tb_decode_pattern_trigger.sv
// Randomized and directed bench for decode_pattern_trigger against a window/queue-level reference model.
module tb_decode_pattern_trigger;

    localparam int PB      = 4;
    localparam int STRETCH = 127;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_dat = '0;
    logic        byte_vld = 1'b0;
    logic [31:0] pattern = 32'hDEADBEEF;
    logic [31:0] mask = '1;
    logic [7:0]  match_count = 8'd1;
    logic        rearm = 1'b0;
    logic        arm = 1'b0;
    logic        disarm = 1'b0;
`ifdef DECODE_TRIG_TIMEOUT_EN
    logic [15:0] timeout = '0;
`endif
    logic        trig_out;
    logic        armed;
    logic [7:0]  match_total;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;

    decode_pattern_trigger #(
        .PATTERN_BYTES  (PB),
        .COUNT_W        (8),
        .STRETCH_CYCLES (STRETCH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .byte_i        (byte_dat),
        .byte_valid_i  (byte_vld),
        .pattern_i     (pattern),
        .mask_i        (mask),
        .match_count_i (match_count),
        .rearm_i       (rearm),
        .arm_i         (arm),
        .disarm_i      (disarm),
`ifdef DECODE_TRIG_TIMEOUT_EN
        .timeout_i     (timeout),
`endif
        .trig_out      (trig_out),
        .armed_o       (armed),
        .match_total_o (match_total),
        .state_o       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // Reference model: 0 idle, 1 armed, 2 fire. Window kept as a 32-bit word, lane 0 in the low byte.
    int          m_st, m_rem, m_tot, m_left, m_fill, m_gap;
    logic [31:0] m_word;
    bit          m_ev_a, m_ev_b;

    function automatic bit window_matches();
        logic [63:0] filled;
        filled = (64'd1 << (8 * m_fill)) - 64'd1;
        return (mask != 0) && (((m_word ^ pattern) & mask) == 0) && ((mask & ~filled[31:0]) == 0);
    endfunction

    task automatic m_edge();
        bit m, clr;
        int reload;
        if (reset) begin
            m_st = 0; m_rem = 0; m_tot = 0; m_left = 0; m_fill = 0; m_gap = 0;
            m_word = '0; m_ev_a = 0; m_ev_b = 0;
            return;
        end
        reload = (match_count == 0) ? 1 : int'(match_count);
        m = m_ev_b;
        m_ev_b = m_ev_a;
        clr = 0;
        if (disarm) begin
            m_st = 0; clr = 1;
        end else if (m_st == 0) begin
            if (arm) begin m_st = 1; m_rem = reload; m_tot = 0; clr = 1; end
        end else if (m_st == 1) begin
            if (arm) begin
                m_rem = reload; m_tot = 0; clr = 1;
            end else if (m) begin
                if (m_tot < 255) m_tot++;
                m_rem--;
                if (m_rem <= 0) begin m_st = 2; m_left = STRETCH; end
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (rearm) begin m_st = 1; m_rem = reload; clr = 1; end
                else m_st = 0;
            end
        end
`ifdef DECODE_TRIG_TIMEOUT_EN
        if (byte_vld) m_gap = 0;
        else if (timeout != 0) begin
            if (m_gap == int'(timeout)) clr = 1;
            else m_gap++;
        end
`endif
        if (byte_vld) m_word = {m_word[23:0], byte_dat};
        if (clr) m_fill = 0;
        else if (byte_vld && m_fill < PB) m_fill++;
        m_ev_a = byte_vld && window_matches();
    endtask

    task automatic cyc(input bit bv, input logic [7:0] b, input bit a, input bit d);
        @(negedge clk);
        byte_vld = bv; byte_dat = b; arm = a; disarm = d;
        @(posedge clk);
        m_edge();
        cyc_n++;
        #1;
        if (!reset) begin
            chk("trig", {31'd0, trig_out}, {31'd0, m_st == 2});
            chk("state", {30'd0, state}, m_st);
            chk("armed", {31'd0, armed}, {31'd0, m_st == 1});
            chk("total", {24'd0, match_total}, m_tot);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0);
    endtask

    task automatic send_frame(input logic [31:0] f);
        for (int i = 3; i >= 0; i--) cyc(1, f[8*i +: 8], 0, 0);
    endtask

    task automatic run_count(input int n, output int highs, output int rises);
        bit prev;
        prev = trig_out; highs = 0; rises = 0;
        for (int i = 0; i < n; i++) begin
            idle(1);
            if (trig_out) highs++;
            if (trig_out && !prev) rises++;
            prev = trig_out;
        end
    endtask

    initial begin
        int rise_at, ef_at, len, highs, rises;
        logic [31:0] pat_v;
        int seq;

        reset = 1'b1;
        idle(3);
        chk("rst_trig", {31'd0, trig_out}, 0);
        chk("rst_state", {30'd0, state}, 0);
        chk("rst_armed", {31'd0, armed}, 0);
        chk("rst_total", {24'd0, match_total}, 0);
        reset = 1'b0;
        idle(2);

        // Single match, count 1: latency and stretch length
        cyc(0, 0, 1, 0);
        send_frame(32'hDEADBEEF);
        ef_at = cyc_n;
        rise_at = -1;
        for (int i = 0; i < 10 && rise_at < 0; i++) begin
            idle(1);
            if (trig_out) rise_at = cyc_n;
        end
        chk("trig_latency", rise_at - ef_at, 2);
        len = 1;
        for (int i = 0; i < 300; i++) begin
            idle(1);
            if (trig_out) len++;
            else break;
        end
        chk("trig_len", len, STRETCH);
        chk("idle_after", {30'd0, state}, 0);

        // Count 2: fires only on the second frame
        match_count = 8'd2;
        cyc(0, 0, 1, 0);
        send_frame(32'hDEADBEEF);
        idle(3);
        chk("cnt2_total1", {24'd0, match_total}, 1);
        chk("cnt2_nofire", {31'd0, trig_out}, 0);
        send_frame(32'hDEADBEEF);
        idle(2);
        chk("cnt2_total2", {24'd0, match_total}, 2);
        chk("cnt2_fire", {31'd0, trig_out}, 1);
        idle(130);
        match_count = 8'd1;

        // Partial mask on lane 0
        pattern = 32'hDEADBEE0; mask = 32'hFFFFFFF0;
        idle(2);
        cyc(0, 0, 1, 0);
        send_frame(32'hDEADBEE7);
        idle(2);
        chk("mask_hit", {31'd0, trig_out}, 1);
        idle(130);
        cyc(0, 0, 1, 0);
        send_frame(32'hDEADBED7);
        idle(3);
        chk("mask_miss", {31'd0, trig_out}, 0);
        cyc(0, 0, 0, 1);
        pattern = 32'hDEADBEEF; mask = '1;
        idle(3);

        // Short frame after arm, then an extra byte
        cyc(0, 0, 1, 0);
        cyc(1, 8'hAD, 0, 0); cyc(1, 8'hBE, 0, 0); cyc(1, 8'hEF, 0, 0);
        idle(3);
        chk("short_nofire", {31'd0, trig_out}, 0);
        cyc(1, 8'hAD, 0, 0);
        idle(3);
        chk("shifted_nofire", {31'd0, trig_out}, 0);

        // Re-arm: two spaced frames give two pulses; then disarm during FIRE
        rearm = 1'b1;
        cyc(0, 0, 1, 0);
        send_frame(32'hDEADBEEF);
        run_count(200, highs, rises);
        send_frame(32'hDEADBEEF);
        run_count(200, len, seq);
        chk("rearm_rises", rises + seq, 2);
        chk("rearm_highs", highs + len, 2 * STRETCH);
        send_frame(32'hDEADBEEF);
        idle(10);
        chk("fire_before_disarm", {30'd0, state}, 2);
        cyc(0, 0, 0, 1);
        chk("disarm_trig", {31'd0, trig_out}, 0);
        chk("disarm_state", {30'd0, state}, 0);
        rearm = 1'b0;
        idle(3);

`ifdef DECODE_TRIG_TIMEOUT_EN
        timeout = 16'd50;
        cyc(0, 0, 1, 0);
        cyc(1, 8'hDE, 0, 0); cyc(1, 8'hAD, 0, 0);
        idle(60);
        cyc(1, 8'hBE, 0, 0); cyc(1, 8'hEF, 0, 0);
        idle(3);
        chk("timeout_nofire", {31'd0, trig_out}, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        cyc(1, 8'hDE, 0, 0); cyc(1, 8'hAD, 0, 0);
        idle(40);
        cyc(1, 8'hBE, 0, 0); cyc(1, 8'hEF, 0, 0);
        idle(2);
        chk("gap_fire", {31'd0, trig_out}, 1);
        idle(130);
`endif

        // Randomized epochs; configuration only changes while idle with no bytes in flight
        for (int ep = 0; ep < 16; ep++) begin
            cyc(0, 0, 0, 1);
            idle(3);
            pattern = $urandom;
            case ($urandom_range(0, 3))
                0: mask = '1;
                1: mask = $urandom;
                2: mask = 32'hF0F0FFFF;
                default: mask = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'h00FF00FF;
            endcase
            match_count = 8'($urandom_range(0, 3));
            rearm = 1'($urandom_range(0, 1));
`ifdef DECODE_TRIG_TIMEOUT_EN
            timeout = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(3, 12));
`endif
            idle(3);
            cyc(0, 0, 1, 0);
            seq = 3;
            pat_v = pattern;
            for (int c = 0; c < 400; c++) begin
                bit bv, a, d;
                logic [7:0] b;
                bv = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 4) == 0) b = 8'($urandom);
                else b = pat_v[8*seq +: 8];
                if (bv) seq = (seq == 0) ? 3 : seq - 1;
                a = ($urandom_range(0, 299) == 0);
                d = ($urandom_range(0, 499) == 0);
                cyc(bv, b, a, d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
